// File: rtl/data_memory_bank.sv
// Byte-addressable 32-bit data memory bank with a zeroing INIT sweep after reset and 1-cycle responses.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned half/word accesses as errors.
module data_memory_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  generate
    if (DEPTH_WORDS < 4 || DEPTH_WORDS > 65536 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two in 4..65536");
    end
    if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
      $error("ADDR_W too narrow for DEPTH_WORDS");
    end
  endgenerate

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_cnt;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             out_of_range, bad_size, misalign, req_err;
  logic [31:0]      rd_word, load_data, wr_data;
  logic [3:0]       wmask;

  logic             vld_p1, err_p1;
  logic [31:0]      rdata_p1;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    return uns ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

  assign req_ready    = (state_q == IDLE);
  assign accept       = req_valid && req_ready;
  assign idx          = req_addr[IDX_W+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign bad_size     = (req_size == 2'b11);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = out_of_range || bad_size || misalign;

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt == IDX_W'(DEPTH_WORDS - 1)) state_d = IDLE;
  end

  // Load path: lane select and extension on the word being addressed this cycle
  always_comb begin
    rd_word   = mem[idx];
    load_data = 32'h0;
    case (req_size)
      2'b00:   load_data = ext_byte(rd_word[{lane, 3'b000} +: 8], req_unsigned);
      2'b01:   load_data = ext_half(req_addr[1] ? rd_word[31:16] : rd_word[15:0], req_unsigned);
      2'b10:   load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    wmask   = 4'b0000;
    wr_data = 32'h0;
    case (req_size)
      2'b00: begin
        wmask   = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wmask   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        wmask   = 4'b1111;
        wr_data = req_wdata;
      end
      default: begin
        wmask   = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        mem[init_cnt] <= 32'h0;
      end else if (accept && req_write && !req_err) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Response stage: registered one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INIT;
      init_cnt <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
      vld_p1   <= accept;
      err_p1   <= accept && req_err;
      rdata_p1 <= (accept && !req_write && !req_err) ? load_data : 32'h0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_err   = err_p1;
  assign rsp_rdata = rdata_p1;

endmodule
